// File: rtl/regfile_hazard_ctrl.sv
// regfile_hazard_ctrl
// Issue-side scoreboard for the 32x64 integer register file. Decodes rs1/rs2/rd
// of the candidate instruction, tracks registers with writes in flight, holds
// issue on RAW / WAW / full-scoreboard hazards, and sequences a drain so the
// pipeline can be quiesced before a flush.
// Optional feature: define REGFILE_HAZARD_BYPASS_EN to let a same-cycle
// write-back resolve RAW/WAW hazards on its register (write-through regfile).
module regfile_hazard_ctrl #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [31:0] issue_instr,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        drain_req,
    output logic        issue_fire,
    output logic        stall,
    output logic [31:0] pending,
    output logic [4:0]  outstanding,
    output logic        drain_done,
    output logic        wb_err
);

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [4:0] MAX_CNT   = 5'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] pending_reg;
    logic [31:0] pending_next;
    logic [4:0]  outstanding_reg;
    logic        drain_done_reg;
    logic        wb_err_reg;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic [31:0] hazard_view;
    logic        hazard;
    logic        set_en;
    logic        clr_en;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        unused_instr_bits;

    assign opcode = issue_instr[6:0];
    assign rd     = issue_instr[11:7];
    assign rs1    = issue_instr[19:15];
    assign rs2    = issue_instr[24:20];
    // funct3/funct7 do not affect register usage
    assign unused_instr_bits = ^{issue_instr[31:25], issue_instr[14:12]};

    // Classify the opcode into source usage and destination write
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_R_TYPE: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            OP_LOAD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default:   ;
        endcase
        // a write to x0 is discarded, so it never touches the scoreboard
        if (rd == 5'd0) writes_rd = 1'b0;
    end

`ifdef REGFILE_HAZARD_BYPASS_EN
    // The completing write-back is forwarded by the regfile write-through,
    // so its register no longer counts as busy for this cycle's hazards.
    assign hazard_view = pending_reg & ~(wb_valid ? (32'd1 << wb_rd) : 32'd0);
`else
    assign hazard_view = pending_reg;
`endif

    // RAW on used sources, WAW on rd, or no free scoreboard slot
    always_comb begin
        hazard = (uses_rs1 & hazard_view[rs1])
               | (uses_rs2 & hazard_view[rs2])
               | (writes_rd & hazard_view[rd])
               | (writes_rd & (outstanding_reg == MAX_CNT));
    end

    assign stall      = issue_valid & (hazard | (state_reg != ST_RUN));
    assign issue_fire = issue_valid & ~stall;

    // Only write-backs to a genuinely pending register retire an entry
    assign set_en   = issue_fire & writes_rd;
    assign clr_en   = wb_valid & (wb_rd != 5'd0) & pending_reg[wb_rd];
    assign set_mask = set_en ? (32'd1 << rd) : 32'd0;
    assign clr_mask = clr_en ? (32'd1 << wb_rd) : 32'd0;

    // Per-register next state: a set wins over a same-cycle clear; x0 stays 0
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb
            if (gi == 0) begin : g_x0
                assign pending_next[gi] = 1'b0;
            end else begin : g_xn
                assign pending_next[gi] = set_mask[gi] | (pending_reg[gi] & ~clr_mask[gi]);
            end
        end
    endgenerate

    // Scoreboard bitmap, population count and sticky write-back error
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg     <= 32'd0;
            outstanding_reg <= 5'd0;
            wb_err_reg      <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (set_en && !clr_en)
                outstanding_reg <= outstanding_reg + 5'd1;
            else if (clr_en && !set_en)
                outstanding_reg <= outstanding_reg - 5'd1;
            if (wb_valid && !clr_en)
                wb_err_reg <= 1'b1;
        end
    end

    // Drain sequencer: RUN -> DRAIN -> DONE (pulse) -> RUN or HOLD
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_RUN;
            drain_done_reg <= 1'b0;
        end else begin
            drain_done_reg <= 1'b0;
            case (state_reg)
                ST_RUN:   if (drain_req) state_reg <= ST_DRAIN;
                ST_DRAIN: if (outstanding_reg == 5'd0) begin
                    state_reg      <= ST_DONE;
                    drain_done_reg <= 1'b1;
                end
                ST_DONE:  state_reg <= drain_req ? ST_HOLD : ST_RUN;
                ST_HOLD:  if (!drain_req) state_reg <= ST_RUN;
                default:  state_reg <= ST_RUN;
            endcase
        end
    end

    assign pending     = pending_reg;
    assign outstanding = outstanding_reg;
    assign drain_done  = drain_done_reg;
    assign wb_err      = wb_err_reg;

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// Testbench for regfile_hazard_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural scoreboard model.
module tb_regfile_hazard_ctrl;

    localparam int MAXO = 4;
`ifdef REGFILE_HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;
    localparam logic [6:0] OT_OP = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_instr = 32'd0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic        drain_req = 1'b0;
    logic        issue_fire;
    logic        stall;
    logic [31:0] pending;
    logic [4:0]  outstanding;
    logic        drain_done;
    logic        wb_err;

    int errors = 0;
    int checks = 0;

    // model state: set of in-flight registers and a drain phase
    bit    m_inflight[32];
    int    m_phase;          // 0 run, 1 draining, 2 done, 3 hold
    bit    m_err;
    bit    m_done;
    bit    exp_fire;
    logic  obs_fire;
    logic  obs_stall;

    regfile_hazard_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_instr(issue_instr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .drain_req(drain_req),
        .issue_fire(issue_fire), .stall(stall), .pending(pending),
        .outstanding(outstanding), .drain_done(drain_done), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
        return {7'd0, s2, s1, 3'd0, d, op};
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_inflight[i];
        return n;
    endfunction

    function automatic logic [31:0] m_bitmap();
        logic [31:0] b = 32'd0;
        for (int i = 0; i < 32; i++) b[i] = m_inflight[i];
        return b;
    endfunction

    // a register blocks issue if its write is in flight and not forwarded now
    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0 || !m_inflight[r]) return 1'b0;
        if (BYP && wb_valid && wb_rd == r) return 1'b0;
        return 1'b1;
    endfunction

    // one clock cycle: check issue outputs, advance the model, check state
    task automatic step();
        logic [6:0] op;
        logic [4:0] d, s1, s2;
        bit r1, r2, wr, hz;
        int cnt0;
        @(negedge clk);
        op = issue_instr[6:0]; d = issue_instr[11:7];
        s1 = issue_instr[19:15]; s2 = issue_instr[24:20];
        r1 = (op == R_OP) || (op == LD_OP) || (op == ST_OP) || (op == BR_OP);
        r2 = (op == R_OP) || (op == ST_OP) || (op == BR_OP);
        wr = ((op == R_OP) || (op == LD_OP)) && (d != 5'd0);
        hz = (r1 && m_busy(s1)) || (r2 && m_busy(s2)) || (wr && m_busy(d))
             || (wr && m_count() == MAXO);
        exp_fire = issue_valid && !hz && (m_phase == 0);
        obs_fire = issue_fire;
        obs_stall = stall;
        chk("issue_fire", obs_fire, exp_fire);
        chk("stall", obs_stall, issue_valid && !exp_fire);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_inflight[i] = 1'b0;
            m_phase = 0; m_err = 1'b0; m_done = 1'b0;
        end else begin
            cnt0 = m_count();
            m_done = (m_phase == 1) && (cnt0 == 0);
            case (m_phase)
                0: if (drain_req) m_phase = 1;
                1: if (cnt0 == 0) m_phase = 2;
                2: m_phase = drain_req ? 3 : 0;
                default: if (!drain_req) m_phase = 0;
            endcase
            if (wb_valid) begin
                if (wb_rd == 5'd0 || !m_inflight[wb_rd]) m_err = 1'b1;
                else m_inflight[wb_rd] = 1'b0;
            end
            if (exp_fire && wr) m_inflight[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("pending", pending, m_bitmap());
        chk("outstanding", {27'd0, outstanding}, m_count());
        chk("drain_done", drain_done, m_done);
        chk("wb_err", wb_err, m_err);
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit wv,
                         input logic [4:0] wr_reg, input bit dr);
        issue_valid = v; issue_instr = ins; wb_valid = wv; wb_rd = wr_reg; drain_req = dr;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int fires;
        int pulses;
        logic [4:0] q[$];

        // reset state
        @(posedge clk); #1;
        do_reset();
        chk("rst_pending", pending, 32'd0);
        chk("rst_outstanding", {27'd0, outstanding}, 32'd0);
        chk("rst_wb_err", wb_err, 1'b0);
        chk("rst_drain_done", drain_done, 1'b0);

        // idle issue: add x3,x1,x2
        drive(1'b1, mk(R_OP, 5'd3, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
        chk("idle_fire", obs_fire, 1'b1);
        chk("idle_pending", pending, 32'h0000_0008);
        chk("idle_outstanding", {27'd0, outstanding}, 32'd1);
        drive(1'b0, 32'd0, 1'b1, 5'd3, 1'b0);

        // RAW: load x5 at cycle 0, dependent from cycle 1, write-back at 3
        drive(1'b1, mk(LD_OP, 5'd5, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        drive(1'b1, mk(R_OP, 5'd6, 5'd5, 5'd0), 1'b0, 5'd0, 1'b0);
        chk("raw_c1_stall", obs_stall, 1'b1);
        drive(1'b1, mk(R_OP, 5'd6, 5'd5, 5'd0), 1'b0, 5'd0, 1'b0);
        chk("raw_c2_stall", obs_stall, 1'b1);
        drive(1'b1, mk(R_OP, 5'd6, 5'd5, 5'd0), 1'b1, 5'd5, 1'b0);
        chk("raw_c3_fire", obs_fire, BYP);
        fires = int'(obs_fire);
        drive(!obs_fire, mk(R_OP, 5'd6, 5'd5, 5'd0), 1'b0, 5'd0, 1'b0);
        fires += int'(obs_fire);
        chk("raw_fire_once", fires, 1);
        chk("raw_pending", pending, 32'h0000_0040);
        drive(1'b0, 32'd0, 1'b1, 5'd6, 1'b0);

        // full scoreboard
        for (int r = 1; r <= 4; r++)
            drive(1'b1, mk(LD_OP, 5'(r), 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        chk("full_pending", pending, 32'h0000_001e);
        drive(1'b1, mk(LD_OP, 5'd6, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        chk("full_ld_stall", obs_stall, 1'b1);
        drive(1'b1, mk(ST_OP, 5'd0, 5'd7, 5'd8), 1'b0, 5'd0, 1'b0);
        chk("full_store_fire", obs_fire, 1'b1);
        drive(1'b1, mk(LD_OP, 5'd6, 5'd0, 5'd0), 1'b1, 5'd1, 1'b0);
        chk("full_wb_cycle_stall", obs_stall, 1'b1);
        drive(1'b1, mk(LD_OP, 5'd6, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        chk("full_after_wb_fire", obs_fire, 1'b1);
        foreach (q[i]) q.delete(i);
        drive(1'b0, 32'd0, 1'b1, 5'd2, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 5'd3, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 5'd4, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 5'd6, 1'b0);
        chk("full_cleared", pending, 32'd0);

        // x0 handling
        drive(1'b1, mk(R_OP, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        chk("x0_fire", obs_fire, 1'b1);
        chk("x0_pending", pending, 32'd0);
        drive(1'b0, 32'd0, 1'b1, 5'd0, 1'b0);
        chk("x0_wb_err", wb_err, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("x0_wb_err_sticky", wb_err, 1'b1);

        // drain with two writes in flight
        drive(1'b1, mk(LD_OP, 5'd9, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        drive(1'b1, mk(LD_OP, 5'd10, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        drive(1'b1, mk(ST_OP, 5'd0, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);
        chk("drain_rise_fire", obs_fire, 1'b1);
        pulses = 0;
        drive(1'b1, mk(ST_OP, 5'd0, 5'd1, 5'd2), 1'b1, 5'd9, 1'b1);
        chk("drain_blocked", obs_stall, 1'b1);
        pulses += int'(drain_done);
        drive(1'b1, mk(ST_OP, 5'd0, 5'd1, 5'd2), 1'b1, 5'd10, 1'b1);
        pulses += int'(drain_done);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, mk(ST_OP, 5'd0, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);
            pulses += int'(drain_done);
        end
        chk("drain_pulses", pulses, 1);
        chk("hold_stall", obs_stall, 1'b1);
        drive(1'b1, mk(ST_OP, 5'd0, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
        chk("hold_drop_stall", obs_stall, 1'b1);
        drive(1'b1, mk(ST_OP, 5'd0, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
        chk("resume_fire", obs_fire, 1'b1);

        // reset while draining with three writes in flight
        for (int r = 13; r <= 15; r++)
            drive(1'b1, mk(LD_OP, 5'(r), 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1);
        drive(1'b1, mk(ST_OP, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0, 1'b1);
        chk("mid_draining_stall", obs_stall, 1'b1);
        do_reset();
        chk("mid_pending", pending, 32'd0);
        chk("mid_outstanding", {27'd0, outstanding}, 32'd0);
        chk("mid_wb_err", wb_err, 1'b0);
        drive(1'b1, mk(LD_OP, 5'd20, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
        chk("mid_run_fire", obs_fire, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 5'd13, 1'b0);
        chk("stale_wb_err", wb_err, 1'b1);
        do_reset();

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [6:0] op;
            bit dr;
            int k;
            k = $urandom_range(0, 4);
            op = (k == 0) ? R_OP : (k == 1) ? LD_OP : (k == 2) ? ST_OP : (k == 3) ? BR_OP : OT_OP;
            q.delete();
            for (int i = 1; i < 32; i++) if (m_inflight[i]) q.push_back(5'(i));
            dr = ($urandom_range(0, 19) == 0) ? !drain_req : drain_req;
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                drive($urandom_range(0, 9) < 7,
                      mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                      1'b1, q[$urandom_range(0, q.size() - 1)], dr);
            else
                drive($urandom_range(0, 9) < 7,
                      mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                      1'b0, 5'd0, dr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
